// File: rtl/cr16_exec_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : cr16_exec_pkg                                            |
// | Description : Shared types and constants for the cr16 run-control      |
// |               block: execution state encoding and hex digit width.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package cr16_exec_pkg;

  // Encoding is visible on O_STATE, so the values are fixed.
  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } exec_state_t;

  localparam int DIGIT_BITS = 4;

endpackage : cr16_exec_pkg
`default_nettype wire

// File: rtl/cr16_enable_divider.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : cr16_enable_divider                                      |
// | Description : Programmable period counter. Counts 0..max(div,1)-1 while |
// |               enabled and flags the terminal count combinationally.    |
// | Ports       : clk_i   system clock                                     |
// |               rst_i   synchronous active-high reset                    |
// |               clr_i   force the counter back to 0                      |
// |               en_i    count this cycle                                 |
// |               div_i   period in clocks (0 behaves as 1)                |
// |               tc_o    terminal count reached this cycle                |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module cr16_enable_divider #(
  parameter int P_DIV_WIDTH = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [P_DIV_WIDTH-1:0] div_i,
  output logic                   tc_o
);

  logic [P_DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [P_DIV_WIDTH-1:0] w_last;

  // Divide-by-0 is treated as divide-by-1, so the last count is 0 either way.
  assign w_last = (div_i == '0) ? '0 : (div_i - 1'b1);

  // ">=" rather than "==" so that shrinking the period below the current
  // count terminates on the next compare instead of wrapping the counter.
  assign tc_o = en_i && (cnt_q >= w_last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : (cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : cr16_enable_divider
`default_nettype wire

// File: rtl/seven_segment_hex_mapping.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : seven_segment_hex_mapping                                |
// | Description : Combinational hex nibble to 7-segment glyph decoder.     |
// |               Segments are active high, bit 0 = a ... bit 6 = g.       |
// | Ports       : hex_i [3:0]  nibble to show                              |
// |               seg_o [6:0]  segment pattern {g,f,e,d,c,b,a}             |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module seven_segment_hex_mapping (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    case (hex_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      4'hF: seg_o = 7'h71;
      default: seg_o = 7'h00;
    endcase
  end

endmodule : seven_segment_hex_mapping
`default_nettype wire

// File: rtl/cr16_exec_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : cr16_exec_ctrl                                           |
// | Description : Run-control and debug display for the cr16 core. Makes   |
// |               the core clock-enable (free-run with divider, single     |
// |               step, halt), stops on a PC breakpoint, counts enables,   |
// |               latches the write-port value and drives hex digits.      |
// | Ports       : I_CLK, I_RESET            clock, sync active-high reset  |
// |               I_RUN, I_HALT, I_STEP     command pulses (HALT>RUN>STEP) |
// |               I_DIV                     enable period in clocks        |
// |               I_BREAK_EN, I_BREAK_ADDR  breakpoint arm and address     |
// |               I_PC                      current core PC                |
// |               I_PORT_WRITE, I_PORT_DATA core write port                |
// |               O_CPU_ENABLE              core clock-enable              |
// |               O_STATE                   HALT/RUN/STEP/BREAK            |
// |               O_CYCLE_COUNT             enable pulses issued           |
// |               O_DISPLAY_VALUE           last latched port value        |
// |               O_7_SEGMENT_DISPLAY       per-digit segment patterns     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module cr16_exec_ctrl
  import cr16_exec_pkg::*;
#(
  parameter int P_DATA_WIDTH    = 16,
  parameter int P_ADDRESS_WIDTH = 10,
  parameter int P_DIV_WIDTH     = 24,
  parameter int P_COUNT_WIDTH   = 32,
  parameter int P_START_RUNNING = 0,
  parameter int P_NUM_DIGITS    = P_DATA_WIDTH / 4
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic                           I_RUN,
  input  logic                           I_HALT,
  input  logic                           I_STEP,
  input  logic [P_DIV_WIDTH-1:0]         I_DIV,
  input  logic                           I_BREAK_EN,
  input  logic [P_ADDRESS_WIDTH-1:0]     I_BREAK_ADDR,
  input  logic [P_ADDRESS_WIDTH-1:0]     I_PC,
  input  logic                           I_PORT_WRITE,
  input  logic [P_DATA_WIDTH-1:0]        I_PORT_DATA,
  output logic                           O_CPU_ENABLE,
  output logic [1:0]                     O_STATE,
  output logic [P_COUNT_WIDTH-1:0]       O_CYCLE_COUNT,
  output logic [P_DATA_WIDTH-1:0]        O_DISPLAY_VALUE,
  output logic [P_NUM_DIGITS-1:0][6:0]   O_7_SEGMENT_DISPLAY
);

  localparam exec_state_t C_RESET_STATE = (P_START_RUNNING != 0) ? S_RUN : S_HALT;

  exec_state_t                state_q,  state_d;
  logic                       enable_q, enable_d;
  logic                       skip_q,   skip_d;
  // Remembers whether the pending single step was launched from BREAK.
  logic                       ret_brk_q, ret_brk_d;
  logic [P_COUNT_WIDTH-1:0]   count_q,  count_d;
  logic [P_DATA_WIDTH-1:0]    disp_q,   disp_d;

  logic w_run;
  logic w_tc;
  logic w_bp_hit;

  assign w_run    = (state_q == S_RUN);
  assign w_bp_hit = I_BREAK_EN && (I_PC == I_BREAK_ADDR);

  // Held at 0 outside RUN, so every entry into RUN starts a fresh period.
  cr16_enable_divider #(
    .P_DIV_WIDTH (P_DIV_WIDTH)
  ) u_divider (
    .clk_i (I_CLK),
    .rst_i (I_RESET),
    .clr_i (!w_run),
    .en_i  (w_run),
    .div_i (I_DIV),
    .tc_o  (w_tc)
  );

  always_comb begin
    state_d   = state_q;
    enable_d  = 1'b0;
    skip_d    = skip_q;
    ret_brk_d = ret_brk_q;
    case (state_q)
      S_HALT: begin
        if (I_HALT) begin
          state_d = S_HALT;
        end else if (I_RUN) begin
          state_d = S_RUN;
        end else if (I_STEP) begin
          state_d   = S_STEP;
          ret_brk_d = 1'b0;
        end
      end
      S_RUN: begin
        if (I_HALT) begin
          state_d = S_HALT;
        end else if (w_tc) begin
          // skip lets the first pulse after a resume execute the
          // breakpoint PC instead of re-trapping on it.
          if (w_bp_hit && !skip_q) begin
            state_d = S_BREAK;
          end else begin
            enable_d = 1'b1;
            skip_d   = 1'b0;
          end
        end
      end
      S_STEP: begin
        enable_d = 1'b1;
        state_d  = ret_brk_q ? S_BREAK : S_HALT;
      end
      S_BREAK: begin
        if (I_HALT) begin
          state_d = S_HALT;
        end else if (I_RUN) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end else if (I_STEP) begin
          state_d   = S_STEP;
          ret_brk_d = 1'b1;
        end
      end
      default: state_d = C_RESET_STATE;
    endcase
  end

  assign count_d = count_q + P_COUNT_WIDTH'(enable_q);
  // A strobe only means something while the core is actually clocked.
  assign disp_d  = (I_PORT_WRITE && enable_q) ? I_PORT_DATA : disp_q;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q   <= C_RESET_STATE;
      enable_q  <= 1'b0;
      skip_q    <= 1'b0;
      ret_brk_q <= 1'b0;
      count_q   <= '0;
      disp_q    <= '0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      skip_q    <= skip_d;
      ret_brk_q <= ret_brk_d;
      count_q   <= count_d;
      disp_q    <= disp_d;
    end
  end

  assign O_CPU_ENABLE    = enable_q;
  assign O_STATE         = state_q;
  assign O_CYCLE_COUNT   = count_q;
  assign O_DISPLAY_VALUE = disp_q;

  for (genvar gi = 0; gi < P_NUM_DIGITS; gi++) begin : g_digit
    if ((gi + 1) * DIGIT_BITS <= P_DATA_WIDTH) begin : g_map
      seven_segment_hex_mapping u_hex (
        .hex_i (disp_q[gi*DIGIT_BITS +: DIGIT_BITS]),
        .seg_o (O_7_SEGMENT_DISPLAY[gi])
      );
    end else begin : g_blank
      // Digits beyond the data width have nothing to show.
      assign O_7_SEGMENT_DISPLAY[gi] = 7'h00;
    end
  end

endmodule : cr16_exec_ctrl
`default_nettype wire

// File: tb/tb_cr16_exec_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_cr16_exec_ctrl                                        |
// | Description : Self-checking bench for cr16_exec_ctrl with directed     |
// |               scenarios and a randomized run against a cycle model.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_cr16_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_p = 1'b0, halt_p = 1'b0, step_p = 1'b0;
  logic [23:0] div = '0;
  logic        brk_en = 1'b0;
  logic [9:0]  brk_addr = '0;
  logic [9:0]  pc = '0;
  logic        port_wr = 1'b0;
  logic [15:0] port_data = '0;
  logic        follow_pc = 1'b0;

  logic             O_CPU_ENABLE;
  logic [1:0]       O_STATE;
  logic [31:0]      O_CYCLE_COUNT;
  logic [15:0]      O_DISPLAY_VALUE;
  logic [3:0][6:0]  seg;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  cr16_exec_ctrl dut (
    .I_CLK               (clk),
    .I_RESET             (rst),
    .I_RUN               (run_p),
    .I_HALT              (halt_p),
    .I_STEP              (step_p),
    .I_DIV               (div),
    .I_BREAK_EN          (brk_en),
    .I_BREAK_ADDR        (brk_addr),
    .I_PC                (pc),
    .I_PORT_WRITE        (port_wr),
    .I_PORT_DATA         (port_data),
    .O_CPU_ENABLE        (O_CPU_ENABLE),
    .O_STATE             (O_STATE),
    .O_CYCLE_COUNT       (O_CYCLE_COUNT),
    .O_DISPLAY_VALUE     (O_DISPLAY_VALUE),
    .O_7_SEGMENT_DISPLAY (seg)
  );

  // Reference model: mode 0 halt, 1 run, 2 step, 3 break; phase = clocks
  // already spent in the current enable period.
  int          m_state = 0, m_phase = 0, m_period;
  logic        m_en = 1'b0, m_en_next, m_skip = 1'b0, m_from_brk = 1'b0;
  logic [31:0] m_cnt = '0;
  logic [15:0] m_disp = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_phase = 0; m_en = 1'b0; m_cnt = '0;
      m_disp = '0; m_skip = 1'b0; m_from_brk = 1'b0;
    end else begin
      if (port_wr && m_en) m_disp = port_data;
      m_cnt     = m_cnt + 32'(m_en);
      m_en_next = 1'b0;
      m_period  = (div == 0) ? 1 : int'(div);
      case (m_state)
        0: if (!halt_p && run_p) begin m_state = 1; m_phase = 0; end
           else if (!halt_p && step_p) begin m_state = 2; m_from_brk = 1'b0; end
        1: if (halt_p) m_state = 0;
           else if (m_phase + 1 >= m_period) begin
             m_phase = 0;
             if (brk_en && pc == brk_addr && !m_skip) m_state = 3;
             else begin m_en_next = 1'b1; m_skip = 1'b0; end
           end else m_phase = m_phase + 1;
        2: begin m_en_next = 1'b1; m_state = m_from_brk ? 3 : 0; end
        default:
           if (halt_p) m_state = 0;
           else if (run_p) begin m_state = 1; m_phase = 0; m_skip = 1'b1; end
           else if (step_p) begin m_state = 2; m_from_brk = 1'b1; end
      endcase
      m_en = m_en_next;
    end
  end

  // Advance to the next falling edge; the emulated core moves its PC on
  // to the next instruction during each enabled cycle.
  task automatic tick();
    @(negedge clk);
    if (follow_pc && O_CPU_ENABLE) pc = pc + 10'd1;
  endtask

  task automatic pulse(input logic r, input logic h, input logic s);
    run_p = r; halt_p = h; step_p = s;
    tick();
    run_p = 1'b0; halt_p = 1'b0; step_p = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; div = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if ({O_STATE, O_CPU_ENABLE, O_CYCLE_COUNT} !== {2'b00, 1'b0, 32'd0}) begin
        miscompares++;
        $display("FAIL reset_idle clk %0d: state %b en %b cnt %0d, want 00 0 0", i, O_STATE, O_CPU_ENABLE, O_CYCLE_COUNT);
      end
    end
    vectors++;
    if (O_DISPLAY_VALUE !== 16'h0 || seg[0] !== 7'h3F) begin
      miscompares++;
      $display("FAIL reset_display: value %h seg0 %h, want 0000 3f", O_DISPLAY_VALUE, seg[0]);
    end
  endtask

  task automatic test_run_div4();
    int n_en = 0;
    div = 24'd4;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (O_CPU_ENABLE) n_en++;
      vectors++;
      if ({O_STATE, O_CPU_ENABLE, O_CYCLE_COUNT} !== {m_state[1:0], m_en, m_cnt}) begin
        miscompares++;
        $display("FAIL run_div4 clk %0d: state %0d en %0d cnt %0d, want %0d %0d %0d",
                 i, O_STATE, O_CPU_ENABLE, O_CYCLE_COUNT, m_state, m_en, m_cnt);
      end
    end
    vectors++;
    if (n_en < 9 || n_en > 11 || O_CYCLE_COUNT < 32'd9 || O_CYCLE_COUNT > 32'd11) begin
      miscompares++;
      $display("FAIL run_div4_rate: %0d pulses count %0d, want 10+/-1", n_en, O_CYCLE_COUNT);
    end
    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (O_CPU_ENABLE !== 1'b0 || O_STATE !== 2'b00 || O_CYCLE_COUNT !== m_cnt) begin
        miscompares++;
        $display("FAIL halt_quiet clk %0d: en %b state %b cnt %0d, want 0 00 %0d", i, O_CPU_ENABLE, O_STATE, O_CYCLE_COUNT, m_cnt);
      end
      tick();
    end
  endtask

  task automatic test_step();
    logic [31:0] c0 = m_cnt;
    for (int k = 0; k < 3; k++) begin
      pulse(1'b0, 1'b0, 1'b1);
      vectors++;
      if (O_STATE !== 2'b10 || O_CPU_ENABLE !== 1'b0) begin
        miscompares++;
        $display("FAIL step_state %0d: state %b en %b, want 10 0", k, O_STATE, O_CPU_ENABLE);
      end
      tick();
      vectors++;
      if (O_CPU_ENABLE !== 1'b1 || O_STATE !== 2'b00) begin
        miscompares++;
        $display("FAIL step_pulse %0d: en %b state %b, want 1 00", k, O_CPU_ENABLE, O_STATE);
      end
      for (int j = 0; j < 3; j++) begin
        tick();
        vectors++;
        if (O_CPU_ENABLE !== 1'b0) begin
          miscompares++;
          $display("FAIL step_single %0d/%0d: en %b, want 0", k, j, O_CPU_ENABLE);
        end
      end
    end
    vectors++;
    if (O_CYCLE_COUNT !== c0 + 32'd3) begin
      miscompares++;
      $display("FAIL step_count: got %0d, want %0d", O_CYCLE_COUNT, c0 + 32'd3);
    end
  endtask

  task automatic test_break();
    int n = 0;
    brk_en = 1'b1; brk_addr = 10'h010; pc = 10'h00C; follow_pc = 1'b1;
    div = 24'($urandom_range(1, 3));
    pulse(1'b1, 1'b0, 1'b0);
    while (O_STATE !== 2'b11 && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    if (O_STATE !== 2'b11 || pc !== 10'h010 || O_CPU_ENABLE !== 1'b0) begin
      miscompares++;
      $display("FAIL break_hit: state %b pc %h en %b after %0d clk, want 11 010 0", O_STATE, pc, O_CPU_ENABLE, n);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (O_STATE !== 2'b11 || O_CPU_ENABLE !== 1'b0 || pc !== 10'h010) begin
        miscompares++;
        $display("FAIL break_hold %0d: state %b en %b pc %h, want 11 0 010", i, O_STATE, O_CPU_ENABLE, pc);
      end
    end
    pulse(1'b1, 1'b0, 1'b0);
    n = 0;
    while (!O_CPU_ENABLE && n < 10) begin
      tick();
      n++;
    end
    vectors++;
    if (O_CPU_ENABLE !== 1'b1 || pc !== 10'h011) begin
      miscompares++;
      $display("FAIL break_resume: en %b pc %h, want 1 011", O_CPU_ENABLE, pc);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if ({O_STATE, O_CPU_ENABLE, O_CYCLE_COUNT} !== {m_state[1:0], m_en, m_cnt}) begin
        miscompares++;
        $display("FAIL break_run clk %0d: state %0d en %0d cnt %0d, want %0d %0d %0d",
                 i, O_STATE, O_CPU_ENABLE, O_CYCLE_COUNT, m_state, m_en, m_cnt);
      end
    end
    vectors++;
    if (O_STATE !== 2'b01 || pc <= 10'h011) begin
      miscompares++;
      $display("FAIL break_continue: state %b pc %h, want 01 and pc > 011", O_STATE, pc);
    end
    pulse(1'b0, 1'b1, 1'b0);
    follow_pc = 1'b0; brk_en = 1'b0;
  endtask

  task automatic test_display();
    pulse(1'b0, 1'b0, 1'b1);
    tick();
    port_wr = 1'b1; port_data = 16'hBEEF;
    tick();
    port_wr = 1'b0;
    vectors++;
    if (O_DISPLAY_VALUE !== 16'hBEEF || seg[3] !== 7'h7C || seg[2] !== 7'h79 || seg[0] !== 7'h71) begin
      miscompares++;
      $display("FAIL display_load: value %h seg3 %h seg2 %h seg0 %h, want beef 7c 79 71",
               O_DISPLAY_VALUE, seg[3], seg[2], seg[0]);
    end
    tick(); tick();
    port_wr = 1'b1; port_data = 16'h1234;
    tick();
    port_wr = 1'b0;
    tick();
    vectors++;
    if (O_DISPLAY_VALUE !== 16'hBEEF || seg[3] !== 7'h7C) begin
      miscompares++;
      $display("FAIL display_stalled: value %h seg3 %h, want beef 7c", O_DISPLAY_VALUE, seg[3]);
    end
  endtask

  task automatic test_run_halt_reset();
    div = 24'($urandom_range(2, 6));
    pulse(1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    pulse(1'b1, 1'b1, 1'b0);
    vectors++;
    if (O_STATE !== 2'b00 || O_CPU_ENABLE !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_priority: state %b en %b, want 00 0", O_STATE, O_CPU_ENABLE);
    end
    div = 24'd1;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (O_CPU_ENABLE !== 1'b1 || O_STATE !== 2'b01) begin
        miscompares++;
        $display("FAIL div1_continuous %0d: en %b state %b, want 1 01", i, O_CPU_ENABLE, O_STATE);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({O_STATE, O_CPU_ENABLE, O_CYCLE_COUNT} !== {2'b00, 1'b0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_midrun: state %b en %b cnt %0d, want 00 0 0", O_STATE, O_CPU_ENABLE, O_CYCLE_COUNT);
    end
  endtask

  task automatic test_random();
    logic [3:0][6:0] exp_seg;
    follow_pc = 1'b1;
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      run_p    = ($urandom_range(0, 15) == 0);
      halt_p   = ($urandom_range(0, 29) == 0);
      step_p   = ($urandom_range(0, 9) == 0);
      port_wr  = ($urandom_range(0, 3) == 0);
      port_data = 16'($urandom);
      if ($urandom_range(0, 29) == 0) div = 24'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) brk_en = ~brk_en;
      if ($urandom_range(0, 19) == 0) brk_addr = pc + 10'($urandom_range(0, 4));
      if ($urandom_range(0, 63) == 0) pc = 10'($urandom);
      tick();
      for (int d = 0; d < 4; d++) exp_seg[d] = glyph[m_disp[4*d +: 4]];
      vectors++;
      if ({O_STATE, O_CPU_ENABLE, O_CYCLE_COUNT, O_DISPLAY_VALUE, seg} !==
          {m_state[1:0], m_en, m_cnt, m_disp, exp_seg}) begin
        miscompares++;
        $display("FAIL random clk %0d: state %0d/%0d en %0d/%0d cnt %0d/%0d disp %h/%h seg %h/%h (got/want)",
                 i, O_STATE, m_state, O_CPU_ENABLE, m_en, O_CYCLE_COUNT, m_cnt,
                 O_DISPLAY_VALUE, m_disp, seg, exp_seg);
      end
    end
    rst = 1'b0; run_p = 1'b0; halt_p = 1'b0; step_p = 1'b0; port_wr = 1'b0;
    follow_pc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_div4();
    test_step();
    test_break();
    test_display();
    test_run_halt_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_cr16_exec_ctrl
`default_nettype wire

// File: doc/cr16_exec_ctrl.md
Name: cr16_exec_ctrl

Overview:
- Parametrised run-control and debug-display block between the board I/O and the cr16 core inside the CR16 top level.
- Generates the core's clock-enable:
  - free-run with a programmable divider, or
  - single-step, or
  - halted.
- Stops on a PC breakpoint, counts executed cycles, latches the core's write-port value and drives a generic N-digit hex display.

Parameters:
- P_DATA_WIDTH, 16, width of the write-port value; must be a multiple of 4.
- P_ADDRESS_WIDTH, 10, width of PC and breakpoint address.
- P_DIV_WIDTH, 24, width of the divider setting.
- P_COUNT_WIDTH, 32, width of the executed-cycle counter.
- P_START_RUNNING, 0, 1 = leave reset in RUN, 0 = leave reset in HALT.
- P_NUM_DIGITS, P_DATA_WIDTH/4, number of 7-segment digits driven.

Ports:
- I_CLK  in  1  system clock.
- I_RESET  in  1  synchronous, active-high reset.
- I_RUN  in  1  single-cycle pulse: start free-running.
- I_HALT  in  1  single-cycle pulse: stop.
- I_STEP  in  1  single-cycle pulse: execute one core cycle while stopped.
- I_DIV  in  P_DIV_WIDTH  enable period in clocks; 0 is treated as 1.
- I_BREAK_EN  in  1  breakpoint armed.
- I_BREAK_ADDR  in  P_ADDRESS_WIDTH  breakpoint PC.
- I_PC  in  P_ADDRESS_WIDTH  current core PC.
- I_PORT_WRITE  in  1  core write-port strobe.
- I_PORT_DATA  in  P_DATA_WIDTH  core write-port data.
- O_CPU_ENABLE  out  1  clock-enable to the cr16 core.
- O_STATE  out  2  00 HALT, 01 RUN, 10 STEP, 11 BREAK.
- O_CYCLE_COUNT  out  P_COUNT_WIDTH  number of enable pulses issued.
- O_DISPLAY_VALUE  out  P_DATA_WIDTH  last latched write-port value.
- O_7_SEGMENT_DISPLAY  out  [6:0] x P_NUM_DIGITS  per-digit segments; digit i shows O_DISPLAY_VALUE[4i+3:4i].

Behaviour:
- One clock, I_CLK. Reset is synchronous and active-high on I_RESET. All state is registered.
- Reset values:
  - state = RUN if P_START_RUNNING else HALT.
  - divider counter = 0.
  - O_CPU_ENABLE = 0.
  - O_CYCLE_COUNT = 0.
  - O_DISPLAY_VALUE = 0.
  - skip flag = 0.
- Reset mid-run or mid-step aborts immediately. No enable pulse is issued in the reset cycle.
- Command priority when pulses coincide: I_HALT > I_RUN > I_STEP.
- HALT:
  - I_RUN -> RUN; divider cleared.
  - I_STEP -> STEP.
- RUN:
  - Divider counts 0..max(I_DIV,1)-1.
  - At the terminal count, if I_BREAK_EN, I_PC == I_BREAK_ADDR and skip = 0: go to BREAK with no pulse.
  - Otherwise O_CPU_ENABLE = 1 for exactly the next cycle, counter returns to 0 and skip clears.
  - I_HALT -> HALT; no pulse is issued that cycle.
  - A change of I_DIV takes effect at the next terminal compare. If the counter already exceeds the new value, the terminal count is reached at the next cycle.
- STEP:
  - Issues exactly one O_CPU_ENABLE cycle, then returns to the state it came from (HALT or BREAK).
  - Breakpoint is ignored.
- BREAK:
  - I_STEP -> STEP.
  - I_RUN -> RUN with skip = 1, so the core advances past the breakpoint PC.
  - I_HALT -> HALT.
- Latency:
  - Command pulse to state change: 1 clock.
  - STEP: pulse to O_CPU_ENABLE high is 2 clocks.
  - RUN with I_DIV <= 1: enable is continuous, 1 clock after entering RUN.
- O_CYCLE_COUNT increments on every O_CPU_ENABLE cycle and wraps modulo 2^P_COUNT_WIDTH.
- O_DISPLAY_VALUE:
  - Loads I_PORT_DATA when I_PORT_WRITE && O_CPU_ENABLE; updates 1 clock later.
  - A strobe while the enable is low is ignored, since the core is stalled.
- 7-segment outputs are combinational decodes of O_DISPLAY_VALUE.
- O_STATE reflects the registered state.

Decomposition:
- Shared package cr16_exec_pkg:
  - state enum exec_state_t {S_HALT=0, S_RUN=1, S_STEP=2, S_BREAK=3}.
  - localparam DIGIT_BITS = 4.
- Sub-module cr16_enable_divider: programmable divider with terminal-count output, clear and I_DIV==0 handling.
- 7-segment digits reuse seven_segment_hex_mapping in a generate loop.

Test Plan:
- Reset, P_START_RUNNING=0, I_DIV=0 -> O_STATE=00, O_CPU_ENABLE=0 and O_CYCLE_COUNT=0 for 20 clocks.
- I_RUN, I_DIV=4 -> O_CPU_ENABLE high 1 of every 4 clocks; after 40 clocks O_CYCLE_COUNT=10 (+/-1 on phase); I_HALT -> no further pulses.
- In HALT, three I_STEP pulses 5 clocks apart -> exactly 3 single-cycle enables, each 2 clocks after its pulse; count +3.
- Breakpoint: I_BREAK_EN=1, I_BREAK_ADDR=0x010, I_PC reaches 0x010 while running -> O_STATE=11 with no enable at that PC; I_RUN -> one enable at 0x010, run continues.
- I_PORT_WRITE with data 0xBEEF during an enable -> O_DISPLAY_VALUE=0xBEEF and digit 3 shows B; a strobe with 0x1234 while halted leaves 0xBEEF.
- Simultaneous I_RUN+I_HALT in RUN -> HALT; I_RESET asserted mid-RUN -> next cycle state HALT, count 0, no enable pulse.
